mips_multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sits directly upstream of register_file32 and drives its RegWrite strobe along with the mux selects that form write_register and write_data. It sequences fetch, decode, execute, memory and writeback per instruction, and stalls on a memory-ready handshake. It supports lw, sw, R-type, beq, addi and j, and flags unsupported opcodes.

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/mips_multicycle_control.sv | 159 +++++++++++++++
 tb/tb_mips_multicycle_control.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
//   - opcode constants for the supported instruction subset
//   - FSM state enumeration
//   - ALUOp, PCSrc and ALUSrcB select encodings
//   - is_legal_op(): true for opcodes the controller knows how to sequence
package mips_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEXEC,
        ADDIWB,
        JUMP
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // True for every opcode that has a sequence through the FSM.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (Moore style).
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   opcode          - instr[31:26] from the instruction register
//   mem_ready       - memory completes the current access this cycle
//   IorD .. RegWrite - datapath mux selects and write strobes
//   illegal_op      - pulse in DECODE for an unsupported opcode
//   instr_count     - retired-instruction counter (wraps)
// Outputs decode the registered state only; IRWrite/PCWrite in FETCH are
// additionally qualified by mem_ready. All strobes are forced low in reset.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // State and retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing; retire marks the last cycle of a legal instruction.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWRITE: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default:  state_d = FETCH;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Output decode; defaults are the FETCH selects with all strobes low.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = PCSRC_ALU;
        ALUOp      = ALU_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_FOUR;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                illegal_op = ~is_legal_op(opcode);
            end
            MEMADR, ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD:  IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REGB;
                ALUOp   = ALU_FUNCT;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REGB;
                ALUOp   = ALU_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
            end
            ADDIWB:   RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset is asynchronous, so strobes must drop without waiting for a clock.
        if (!rst) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: a directed instruction
// list followed by randomized instructions, wait states and resets, checked
// every cycle against an instruction-phase model, plus literal checks of
// instruction lengths and counts for the directed part.
module tb_mips_multicycle_control;

    localparam int unsigned CNT_W   = 32;
    localparam int          CYC_MAX = 20000;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0]       PCSrc, ALUOp, ALUSrcB;
    logic             ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
    logic [CNT_W-1:0] instr_count;

    mips_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCSrc(PCSrc), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Instruction classes
    localparam int C_NONE = 0, C_LW = 1, C_SW = 2, C_R = 3, C_BEQ = 4,
                   C_ADDI = 5, C_J = 6, C_ILL = 7;

    typedef struct {
        logic [5:0] op;
        int         fw;      // FETCH cycles with mem_ready low
        int         mw;      // MEMREAD/MEMWRITE cycles with mem_ready low
        bit         rst_in_exec;
        bit         rnd;
    } instr_t;

    typedef struct packed {
        logic       iord, memwrite, irwrite, pcwrite, branch;
        logic [1:0] pcsrc, aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       regdst, memtoreg, regwrite, illegal;
        logic [6:0] care; // iord, pcsrc, aluop, srca, srcb, regdst, memtoreg
    } exp_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h00:   return C_R;
            6'h04:   return C_BEQ;
            6'h08:   return C_ADDI;
            6'h02:   return C_J;
            default: return C_ILL;
        endcase
    endfunction

    // Index of the final phase of each class (phase 0 fetch, 1 decode)
    function automatic int last_step(input int c);
        case (c)
            C_LW:          return 4;
            C_SW, C_R:     return 3;
            C_ADDI:        return 3;
            C_BEQ, C_J:    return 2;
            default:       return 1;
        endcase
    endfunction

    function automatic bit is_wait_step(input int c, input int s);
        return (c == C_LW || c == C_SW) && s == 3;
    endfunction

    // Required outputs for a given instruction phase
    function automatic exp_t expected(input int step, input int c, input logic mr,
                                      input logic r, input logic [5:0] op);
        exp_t e;
        e = '0;
        if (!r || step == 0) begin
            e.srcb    = 2'b01;
            e.care    = 7'b1111100;
            e.irwrite = r & mr;
            e.pcwrite = r & mr;
        end else if (step == 1) begin
            e.srcb    = 2'b11;
            e.care    = 7'b0011100;
            e.illegal = (classify(op) == C_ILL);
        end else begin
            case (c)
                C_LW: begin
                    if (step == 2) begin e.srca = 1; e.srcb = 2'b10; e.care = 7'b0011100; end
                    if (step == 3) begin e.iord = 1; e.care = 7'b1000000; end
                    if (step == 4) begin e.memtoreg = 1; e.regwrite = 1; e.care = 7'b0000011; end
                end
                C_SW: begin
                    if (step == 2) begin e.srca = 1; e.srcb = 2'b10; e.care = 7'b0011100; end
                    if (step == 3) begin e.iord = 1; e.memwrite = 1; e.care = 7'b1000000; end
                end
                C_R: begin
                    if (step == 2) begin e.srca = 1; e.aluop = 2'b10; e.care = 7'b0011100; end
                    if (step == 3) begin e.regdst = 1; e.regwrite = 1; e.care = 7'b0000011; end
                end
                C_BEQ: begin
                    e.srca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = 1;
                    e.care = 7'b0111100;
                end
                C_ADDI: begin
                    if (step == 2) begin e.srca = 1; e.srcb = 2'b10; e.care = 7'b0011100; end
                    if (step == 3) begin e.regwrite = 1; e.care = 7'b0000011; end
                end
                C_J: begin
                    e.pcsrc = 2'b10; e.pcwrite = 1; e.care = 7'b0100000;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    instr_t      iq[$];
    instr_t      cur;
    int          pulses[$];
    int          exp_len[6] = '{4, 8, 6, 3, 3, 2};

    initial begin
        int          step, cls, cyc;
        int unsigned mcount;
        bit          have, prev_rw;
        logic        r_now, mr;
        exp_t        e;
        int          mw_cycles, rw_cycles;
        logic [31:0] cnt_at_p6, cnt_at_p7;
        instr_t      t;

        // Directed instructions
        iq.push_back('{6'h00, 0, 0, 1'b0, 1'b0});
        iq.push_back('{6'h23, 0, 3, 1'b0, 1'b0});
        iq.push_back('{6'h2b, 0, 2, 1'b0, 1'b0});
        iq.push_back('{6'h04, 0, 0, 1'b0, 1'b0});
        iq.push_back('{6'h02, 0, 0, 1'b0, 1'b0});
        iq.push_back('{6'h3f, 0, 0, 1'b0, 1'b0});
        iq.push_back('{6'h08, 0, 0, 1'b1, 1'b0});
        iq.push_back('{6'h00, 2, 0, 1'b0, 1'b0});
        // Random instructions
        for (int i = 0; i < 300; i++) begin
            logic [5:0] legal_ops[6];
            legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
            t.op = (i % 8 == 7) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
            t.fw = $urandom_range(0, 2);
            t.mw = $urandom_range(0, 3);
            t.rst_in_exec = 1'b0;
            t.rnd = 1'b1;
            iq.push_back(t);
        end

        rst = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
        step = 0; cls = C_NONE; mcount = 0; have = 0; prev_rw = 0;
        mw_cycles = 0; rw_cycles = 0; cnt_at_p6 = '1; cnt_at_p7 = '1;
        cur = '{6'h00, 0, 0, 1'b0, 1'b0};

        @(posedge clk); #1;
        for (cyc = 0; cyc < CYC_MAX; cyc++) begin
            if (cyc >= 2 && step == 0 && !have && iq.size() == 0) break;

            r_now = (cyc >= 2);
            if (r_now && step == 0 && !have && iq.size() > 0) begin
                cur  = iq.pop_front();
                have = 1;
            end
            if (have && cur.rst_in_exec && cls == C_ADDI && step == 2) r_now = 0;
            else if (have && cur.rnd && $urandom_range(0, 59) == 0) r_now = 0;

            if (!have) mr = 1'($urandom_range(0, 1));
            else if (step == 0) begin
                mr = (cur.fw == 0);
                if (cur.fw > 0) cur.fw--;
            end else if (is_wait_step(cls, step)) begin
                mr = (cur.mw == 0);
                if (cur.mw > 0) cur.mw--;
            end else mr = 1'($urandom_range(0, 1));

            rst       = r_now;
            mem_ready = mr;
            opcode    = have ? cur.op : 6'($urandom);

            #4;
            e = expected(step, cls, mr, r_now, opcode);
            chk("MemWrite",    32'(MemWrite),   32'(e.memwrite));
            chk("IRWrite",     32'(IRWrite),    32'(e.irwrite));
            chk("PCWrite",     32'(PCWrite),    32'(e.pcwrite));
            chk("Branch",      32'(Branch),     32'(e.branch));
            chk("RegWrite",    32'(RegWrite),   32'(e.regwrite));
            chk("illegal_op",  32'(illegal_op), 32'(e.illegal));
            chk("instr_count", instr_count,     r_now ? mcount : 32'd0);
            if (e.care[6]) chk("IorD",     32'(IorD),     32'(e.iord));
            if (e.care[5]) chk("PCSrc",    32'(PCSrc),    32'(e.pcsrc));
            if (e.care[4]) chk("ALUOp",    32'(ALUOp),    32'(e.aluop));
            if (e.care[3]) chk("ALUSrcA",  32'(ALUSrcA),  32'(e.srca));
            if (e.care[2]) chk("ALUSrcB",  32'(ALUSrcB),  32'(e.srcb));
            if (e.care[1]) chk("RegDst",   32'(RegDst),   32'(e.regdst));
            if (e.care[0]) chk("MemtoReg", 32'(MemtoReg), 32'(e.memtoreg));
            chk("regwrite_back_to_back", 32'(prev_rw & RegWrite), 32'd0);
            prev_rw = RegWrite;

            if (pulses.size() < 7) begin
                if (MemWrite) mw_cycles++;
                if (RegWrite) rw_cycles++;
            end
            if (IRWrite) begin
                pulses.push_back(cyc);
                if (pulses.size() == 7) cnt_at_p6 = instr_count;
                if (pulses.size() == 8) cnt_at_p7 = instr_count;
            end

            // Advance the instruction-phase model
            if (!r_now) begin
                step = 0; cls = C_NONE; mcount = 0; have = 0;
            end else if (step == 0) begin
                if (mr) step = 1;
            end else if (step == 1) begin
                cls = classify(opcode);
                if (cls == C_ILL) begin step = 0; have = 0; end
                else step = 2;
            end else if (is_wait_step(cls, step) && !mr) begin
                step = step;
            end else if (step == last_step(cls)) begin
                step = 0; mcount++; have = 0;
            end else begin
                step++;
            end

            @(posedge clk); #1;
        end

        chk("run_complete", 32'(iq.size()), 32'd0);
        chk("pulse_count", 32'(pulses.size() >= 8), 32'd1);
        if (pulses.size() >= 7) begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("instr_len_%0d", i), 32'(pulses[i+1] - pulses[i]), 32'(exp_len[i]));
        end
        chk("count_before_addi", cnt_at_p6, 32'd5);
        chk("count_after_reset", cnt_at_p7, 32'd0);
        chk("memwrite_cycles",   32'(mw_cycles), 32'd3);
        chk("regwrite_cycles",   32'(rw_cycles), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
